crc_stream_engine: RTL and testbench



---
 rtl/crc_stream_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_crc_stream_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming multi-word CRC engine with per-frame config and byte count.
// Optional CRC_STREAM_CHECK_EN adds cfgCheck input and crcMatch output.
module crc_stream_engine #(
  parameter int CRC_WIDTH = 16,
  parameter int DWIDTH    = 32,
  parameter int LEN_W     = 16,
  parameter int NB_W      = $clog2(DWIDTH/8+1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [CRC_WIDTH-1:0] cfgPoly,
  input  logic [CRC_WIDTH-1:0] cfgInit,
  input  logic [CRC_WIDTH-1:0] cfgFinalXor,
  input  logic                 cfgRefIn,
  input  logic                 cfgRefOut,
`ifdef CRC_STREAM_CHECK_EN
  input  logic [CRC_WIDTH-1:0] cfgCheck,
  output logic                 crcMatch,
`endif
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [DWIDTH-1:0]    inData,
  input  logic                 inFirst,
  input  logic                 inLast,
  input  logic [NB_W-1:0]      inNumBytes,
  output logic                 crcValid,
  input  logic                 crcReady,
  output logic [CRC_WIDTH-1:0] crcOut,
  output logic [LEN_W-1:0]     crcLen,
  output logic                 busy
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int SW     = LEN_W + NB_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic logic [CRC_WIDTH-1:0] fold(
    input logic [CRC_WIDTH-1:0] crc_in,
    input logic [CRC_WIDTH-1:0] poly,
    input logic [DWIDTH-1:0]    data,
    input logic [NB_W-1:0]      nb,
    input logic                 refin
  );
    logic [CRC_WIDTH-1:0] c;
    logic [7:0]           b;
    logic [7:0]           br;
    logic                 fb;
    c = crc_in;
    for (int i = 0; i < NBYTES; i++) begin
      b = data[DWIDTH-1-8*i -: 8];
      for (int j = 0; j < 8; j++) br[j] = b[7-j];
      if (refin) b = br;
      if (NB_W'(i) < nb) begin
        for (int j = 7; j >= 0; j--) begin
          fb = c[CRC_WIDTH-1] ^ b[j];
          c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] rev_crc(
    input logic [CRC_WIDTH-1:0] v
  );
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic [CRC_WIDTH-1:0] poly_q, poly_d;
  logic [CRC_WIDTH-1:0] fxor_q, fxor_d;
  logic                 refin_q, refin_d;
  logic                 refout_q, refout_d;
  logic [LEN_W-1:0]     len_acc_q, len_acc_d;
  logic [CRC_WIDTH-1:0] crc_out_q, crc_out_d;
  logic [LEN_W-1:0]     crc_len_q, crc_len_d;
  logic                 crc_valid_q, crc_valid_d;
  logic                 busy_q, busy_d;
`ifdef CRC_STREAM_CHECK_EN
  logic [CRC_WIDTH-1:0] check_q, check_d;
  logic                 match_q, match_d;
  logic [CRC_WIDTH-1:0] cur_check;
`endif

  logic                 in_ready;
  logic                 accept;
  logic                 start;
  logic [CRC_WIDTH-1:0] cur_poly;
  logic [CRC_WIDTH-1:0] cur_fxor;
  logic                 cur_refin;
  logic                 cur_refout;
  logic [CRC_WIDTH-1:0] crc_base;
  logic [CRC_WIDTH-1:0] crc_word;
  logic [CRC_WIDTH-1:0] crc_final;
  logic [NB_W-1:0]      nb_v;
  logic [LEN_W-1:0]     len_base;
  logic [SW-1:0]        len_sum;
  logic [LEN_W-1:0]     len_next;

  assign in_ready = ~crc_valid_q | crcReady;
  assign inReady  = in_ready;
  assign crcValid = crc_valid_q;
  assign crcOut   = crc_out_q;
  assign crcLen   = crc_len_q;
  assign busy     = busy_q;
`ifdef CRC_STREAM_CHECK_EN
  assign crcMatch = match_q;
`endif

  // Datapath and next-state: fold accepted word, latch config at frame start
  always_comb begin
    accept     = inValid && in_ready;
    start      = accept && ((state_q != ACCUM) || inFirst);
    cur_poly   = start ? cfgPoly     : poly_q;
    cur_fxor   = start ? cfgFinalXor : fxor_q;
    cur_refin  = start ? cfgRefIn    : refin_q;
    cur_refout = start ? cfgRefOut   : refout_q;
    crc_base   = start ? cfgInit     : crc_q;
    len_base   = start ? '0          : len_acc_q;
`ifdef CRC_STREAM_CHECK_EN
    cur_check  = start ? cfgCheck    : check_q;
`endif

    nb_v = NB_W'(NBYTES);
    if (inLast && (inNumBytes != '0) &&
        (inNumBytes <= NB_W'(NBYTES)))
      nb_v = inNumBytes;

    crc_word  = fold(crc_base, cur_poly, inData,
                     nb_v, cur_refin);
    crc_final = (cur_refout ? rev_crc(crc_word)
                            : crc_word) ^ cur_fxor;

    len_sum  = SW'(len_base) + SW'(nb_v);
    len_next = (len_sum > SW'({LEN_W{1'b1}}))
             ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];

    state_d     = state_q;
    crc_d       = crc_q;
    poly_d      = poly_q;
    fxor_d      = fxor_q;
    refin_d     = refin_q;
    refout_d    = refout_q;
    len_acc_d   = len_acc_q;
    crc_out_d   = crc_out_q;
    crc_len_d   = crc_len_q;
    crc_valid_d = crc_valid_q;
    busy_d      = busy_q;
`ifdef CRC_STREAM_CHECK_EN
    check_d     = check_q;
    match_d     = match_q;
`endif

    if (accept) begin
      crc_d     = crc_word;
      len_acc_d = len_next;
      poly_d    = cur_poly;
      fxor_d    = cur_fxor;
      refin_d   = cur_refin;
      refout_d  = cur_refout;
`ifdef CRC_STREAM_CHECK_EN
      check_d   = cur_check;
`endif
      if (inLast) begin
        state_d     = DONE;
        crc_out_d   = crc_final;
        crc_len_d   = len_next;
        crc_valid_d = 1'b1;
        busy_d      = 1'b0;
`ifdef CRC_STREAM_CHECK_EN
        match_d     = (crc_final == cur_check);
`endif
      end else begin
        state_d     = ACCUM;
        crc_valid_d = 1'b0;
        busy_d      = 1'b1;
      end
    end else if ((state_q == DONE) && crcReady) begin
      state_d     = IDLE;
      crc_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  // State, latched config, accumulators and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      poly_q      <= '0;
      fxor_q      <= '0;
      refin_q     <= 1'b0;
      refout_q    <= 1'b0;
      len_acc_q   <= '0;
      crc_out_q   <= '0;
      crc_len_q   <= '0;
      crc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
      check_q     <= '0;
      match_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      poly_q      <= poly_d;
      fxor_q      <= fxor_d;
      refin_q     <= refin_d;
      refout_q    <= refout_d;
      len_acc_q   <= len_acc_d;
      crc_out_q   <= crc_out_d;
      crc_len_q   <= crc_len_d;
      crc_valid_q <= crc_valid_d;
      busy_q      <= busy_d;
`ifdef CRC_STREAM_CHECK_EN
      check_q     <= check_d;
      match_q     <= match_d;
`endif
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: CRC-16/CCITT-FALSE and CRC-32 instances on one stream.
// Covers handshake, backpressure, abort, length saturation, reset.
module tb_crc_stream_engine;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic [31:0] inData;
  logic        inFirst;
  logic        inLast;
  logic [2:0]  inNumBytes;
  logic        crcReady;

  logic [15:0] poly16;
  logic [15:0] init16;

  logic        inReady16, crcValid16, busy16;
  logic [15:0] crcOut16;
  logic [15:0] crcLen16;
  logic        inReady32, crcValid32, busy32;
  logic [31:0] crcOut32;
  logic [3:0]  crcLen32;

`ifdef CRC_STREAM_CHECK_EN
  logic [15:0] check16;
  logic        match16;
  logic        match32;
`endif

  int total;
  int passed;

  crc_stream_engine #(
    .CRC_WIDTH(16),
    .DWIDTH(32),
    .LEN_W(16)
  ) d16 (
    .clk(clk),
    .rstN(rstN),
    .cfgPoly(poly16),
    .cfgInit(init16),
    .cfgFinalXor(16'h0000),
    .cfgRefIn(1'b0),
    .cfgRefOut(1'b0),
`ifdef CRC_STREAM_CHECK_EN
    .cfgCheck(check16),
    .crcMatch(match16),
`endif
    .inValid(inValid),
    .inReady(inReady16),
    .inData(inData),
    .inFirst(inFirst),
    .inLast(inLast),
    .inNumBytes(inNumBytes),
    .crcValid(crcValid16),
    .crcReady(crcReady),
    .crcOut(crcOut16),
    .crcLen(crcLen16),
    .busy(busy16)
  );

  crc_stream_engine #(
    .CRC_WIDTH(32),
    .DWIDTH(32),
    .LEN_W(4)
  ) d32 (
    .clk(clk),
    .rstN(rstN),
    .cfgPoly(32'h04C11DB7),
    .cfgInit(32'hFFFFFFFF),
    .cfgFinalXor(32'hFFFFFFFF),
    .cfgRefIn(1'b1),
    .cfgRefOut(1'b1),
`ifdef CRC_STREAM_CHECK_EN
    .cfgCheck(32'hCBF43926),
    .crcMatch(match32),
`endif
    .inValid(inValid),
    .inReady(inReady32),
    .inData(inData),
    .inFirst(inFirst),
    .inLast(inLast),
    .inNumBytes(inNumBytes),
    .crcValid(crcValid32),
    .crcReady(crcReady),
    .crcOut(crcOut32),
    .crcLen(crcLen32),
    .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] d,
                      input logic f,
                      input logic l,
                      input logic [2:0] nb);
    inData     = d;
    inFirst    = f;
    inLast     = l;
    inNumBytes = nb;
    inValid    = 1'b1;
    @(posedge clk);
    #1;
    inValid    = 1'b0;
    inFirst    = 1'b0;
    inLast     = 1'b0;
    inNumBytes = '0;
  endtask

  task automatic send_vec();
    send(32'h31323334, 1'b1, 1'b0, 3'd0);
    send(32'h35363738, 1'b0, 1'b0, 3'd0);
    send(32'h39000000, 1'b0, 1'b1, 3'd1);
  endtask

  task automatic consume();
    crcReady = 1'b1;
    @(posedge clk);
    #1;
    crcReady = 1'b0;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rstN       = 1'b0;
    inValid    = 1'b0;
    inData     = '0;
    inFirst    = 1'b0;
    inLast     = 1'b0;
    inNumBytes = '0;
    crcReady   = 1'b0;
    poly16     = 16'h1021;
    init16     = 16'hFFFF;
`ifdef CRC_STREAM_CHECK_EN
    check16    = 16'h29B1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", crcValid16, 1'b0);
    chk("rst_busy", busy16, 1'b0);
    chk("rst_out", crcOut16, 16'h0);
    chk("rst_len", crcLen16, 16'h0);
    chk("rst_ready", inReady16, 1'b1);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    send(32'h31323334, 1'b1, 1'b0, 3'd0);
    send(32'h35363738, 1'b0, 1'b0, 3'd0);
    chk("mid_busy", busy16, 1'b1);
    chk("mid_valid", crcValid16, 1'b0);
    send(32'h39000000, 1'b0, 1'b1, 3'd1);
    chk("ccitt_valid", crcValid16, 1'b1);
    chk("ccitt_crc", crcOut16, 16'h29B1);
    chk("ccitt_len", crcLen16, 16'd9);
    chk("ccitt_busy", busy16, 1'b0);
    chk("crc32_valid", crcValid32, 1'b1);
    chk("crc32_crc", crcOut32, 32'hCBF43926);
    chk("crc32_len", crcLen32, 4'd9);
`ifdef CRC_STREAM_CHECK_EN
    chk("match16_hit", match16, 1'b1);
    chk("match32_hit", match32, 1'b1);
`endif

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", inReady16, 1'b0);
      chk("bp_valid", crcValid16, 1'b1);
      chk("bp_crc", crcOut16, 16'h29B1);
      chk("bp_len", crcLen16, 16'd9);
    end

    crcReady = 1'b1;
    inData   = 32'h31323334;
    inFirst  = 1'b1;
    inValid  = 1'b1;
    #1;
    chk("bp_release_ready", inReady16, 1'b1);
    @(posedge clk);
    #1;
    crcReady = 1'b0;
    inValid  = 1'b0;
    inFirst  = 1'b0;
    chk("bp_taken", crcValid16, 1'b0);
    chk("bp_newframe", busy16, 1'b1);
    poly16 = 16'h8005;
    init16 = 16'h0000;
    send(32'h35363738, 1'b0, 1'b0, 3'd0);
    send(32'h39000000, 1'b0, 1'b1, 3'd1);
    chk("latch_crc", crcOut16, 16'h29B1);
    chk("latch_len", crcLen16, 16'd9);
    poly16 = 16'h1021;
    init16 = 16'hFFFF;
    consume();
    chk("consumed", crcValid16, 1'b0);

    send(32'hDEADBEEF, 1'b1, 1'b0, 3'd0);
    send(32'h01020304, 1'b0, 1'b0, 3'd0);
    chk("abort_pre_valid", crcValid16, 1'b0);
    send(32'h31323334, 1'b1, 1'b0, 3'd0);
    chk("abort_restart_valid", crcValid16, 1'b0);
    chk("abort_restart_busy", busy16, 1'b1);
    send(32'h35363738, 1'b0, 1'b0, 3'd0);
    send(32'h39000000, 1'b0, 1'b1, 3'd1);
    chk("abort_crc", crcOut16, 16'h29B1);
    chk("abort_len", crcLen16, 16'd9);
    chk("abort_crc32", crcOut32, 32'hCBF43926);
    consume();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_single", crcValid16, 1'b0);

    send(32'h31323334, 1'b1, 1'b1, 3'd0);
    chk("nb0_len", crcLen16, 16'd4);
    consume();
    send(32'h31323334, 1'b1, 1'b1, 3'd7);
    chk("nb7_len", crcLen16, 16'd4);
    consume();
    send(32'h31323334, 1'b1, 1'b1, 3'd3);
    chk("nb3_len", crcLen16, 16'd3);
    consume();

    send(32'h11111111, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++)
      send(32'h22222222, 1'b0, 1'b0, 3'd0);
    send(32'h33333333, 1'b0, 1'b1, 3'd0);
    chk("len20", crcLen16, 16'd20);
    chk("len_sat", crcLen32, 4'd15);
    consume();

`ifdef CRC_STREAM_CHECK_EN
    check16 = 16'h29B0;
`endif
    send(32'h31323334, 1'b1, 1'b0, 3'd0);
    send(32'h35363738, 1'b0, 1'b0, 3'd0);
    chk("prerst_busy", busy16, 1'b1);
    rstN = 1'b0;
    #1;
    chk("rst_mid_valid", crcValid16, 1'b0);
    chk("rst_mid_busy", busy16, 1'b0);
    chk("rst_mid_out", crcOut16, 16'h0);
    chk("rst_mid_busy32", busy32, 1'b0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", crcValid16, 1'b0);
    chk("post_rst_ready32", inReady32, 1'b1);
    send_vec();
    chk("post_rst_crc", crcOut16, 16'h29B1);
    chk("post_rst_len", crcLen16, 16'd9);
    chk("post_rst_crc32", crcOut32, 32'hCBF43926);
`ifdef CRC_STREAM_CHECK_EN
    chk("match16_miss", match16, 1'b0);
`endif
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
